rst_sequencer: RTL and testbench

RST_SEQUENCER -- requirements
Module: rst_sequencer

---
 rtl/rst_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_rst_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rst_sequencer.sv
// ---------------------------------------------------------------------------
// rst_sequencer
//
// Purpose:
//   Reset sequencer. It synchronizes the release of an asynchronous reset,
//   waits for the clock source to lock, then releases NUM_DOMAINS reset
//   outputs one at a time in ascending order, RELEASE_DELAY cycles apart.
//   A software request or a loss of lock pulls every domain back into
//   reset and starts the sequence again.
//
// Parameters:
//   SYNC_STAGES   - flops on the reset-release path (>= 2)
//   NUM_DOMAINS   - number of sequenced reset outputs (1..8)
//   RELEASE_DELAY - cycles between successive domain releases (1..255)
//   HOLD_CYCLES   - cycles all domains stay in reset after a software
//                   request (1..255)
//
// Ports:
//   clk          in   single clock, rising edge
//   async_rst_ni in   asynchronous assert, active-low reset
//   lock_i       in   clock-source lock, synchronous to clk
//   sw_rst_req_i in   software reset request, single-cycle pulse
//   dom_rst_no   out  per-domain reset, active-low (0 = held in reset)
//   done_o       out  high while every domain is released
//   sw_rst_ack_o out  one-cycle pulse when a software-initiated sequence
//                     completes
// ---------------------------------------------------------------------------
module rst_sequencer #(
  parameter int SYNC_STAGES   = 2,
  parameter int NUM_DOMAINS   = 3,
  parameter int RELEASE_DELAY = 8,
  parameter int HOLD_CYCLES   = 4
) (
  input  logic                   clk,
  input  logic                   async_rst_ni,
  input  logic                   lock_i,
  input  logic                   sw_rst_req_i,
  output logic [NUM_DOMAINS-1:0] dom_rst_no,
  output logic                   done_o,
  output logic                   sw_rst_ack_o
);

  localparam int         KW          = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam logic [7:0] RELOAD      = 8'(RELEASE_DELAY - 1);
  localparam logic [7:0] HOLD_RELOAD = 8'(HOLD_CYCLES - 1);

  localparam logic [2:0] ST_RESET     = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_HOLD      = 3'd2;
  localparam logic [2:0] ST_RELEASE   = 3'd3;
  localparam logic [2:0] ST_RUN       = 3'd4;

  // The state register's RESET -> WAIT_LOCK transition acts as the final
  // flop of the release synchronizer, so only SYNC_STAGES-1 dedicated
  // flops are needed here to give SYNC_STAGES flops in total.
  logic [SYNC_STAGES-2:0] sync_q;

  logic [2:0]             state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [KW-1:0]          k_q, k_d;
  logic                   sw_flag_q, sw_flag_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic                   done_q, done_d;
  logic                   ack_q, ack_d;

  logic [NUM_DOMAINS-1:0] next_mask;
  logic                   last_domain;
  logic                   lock_lost;
  logic                   sw_abort;
  logic                   begin_release;
  logic                   go_run;

  always_ff @(posedge clk or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= 1'b1;
      for (int i = 1; i < SYNC_STAGES - 1; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // One-hot mask of the domain to be released next (index k+1).
  always_comb begin
    next_mask = '0;
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      if (i == int'(k_q) + 1) begin
        next_mask[i] = 1'b1;
      end
    end
  end

  assign last_domain = (int'(k_q) == NUM_DOMAINS - 2);

  // Lock loss outranks a software request arriving on the same edge.
  assign lock_lost = !lock_i &&
                     ((state_q == ST_HOLD) || (state_q == ST_RELEASE) || (state_q == ST_RUN));
  assign sw_abort  = sw_rst_req_i &&
                     ((state_q == ST_RELEASE) || (state_q == ST_RUN));

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    k_d           = k_q;
    sw_flag_d     = sw_flag_q;
    dom_d         = dom_q;
    done_d        = done_q;
    ack_d         = 1'b0;
    begin_release = 1'b0;
    go_run        = 1'b0;

    if (lock_lost) begin
      dom_d     = '0;
      done_d    = 1'b0;
      sw_flag_d = 1'b0;
      state_d   = ST_WAIT_LOCK;
    end else if (sw_abort) begin
      dom_d     = '0;
      done_d    = 1'b0;
      cnt_d     = HOLD_RELOAD;
      sw_flag_d = 1'b1;
      state_d   = ST_HOLD;
    end else begin
      case (state_q)
        ST_RESET: begin
          if (sync_q[SYNC_STAGES-2]) begin
            state_d = ST_WAIT_LOCK;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_i) begin
            begin_release = 1'b1;
          end
        end
        ST_HOLD: begin
          if (cnt_q == 8'd0) begin
            begin_release = 1'b1;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        ST_RELEASE: begin
          if (cnt_q == 8'd0) begin
            dom_d = dom_q | next_mask;
            k_d   = k_q + KW'(1);
            cnt_d = RELOAD;
            if (last_domain) begin
              go_run = 1'b1;
            end
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        ST_RUN: begin
        end
        default: begin
          state_d = ST_RESET;
        end
      endcase
    end

    // Shared entry into the release sequence from WAIT_LOCK and HOLD.
    if (begin_release) begin
      dom_d = NUM_DOMAINS'(1);
      k_d   = '0;
      cnt_d = RELOAD;
      if (NUM_DOMAINS == 1) begin
        go_run = 1'b1;
      end else begin
        state_d = ST_RELEASE;
      end
    end

    if (go_run) begin
      state_d   = ST_RUN;
      done_d    = 1'b1;
      ack_d     = sw_flag_q;
      sw_flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      state_q   <= ST_RESET;
      cnt_q     <= '0;
      k_q       <= '0;
      sw_flag_q <= 1'b0;
      dom_q     <= '0;
      done_q    <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      k_q       <= k_d;
      sw_flag_q <= sw_flag_d;
      dom_q     <= dom_d;
      done_q    <= done_d;
      ack_q     <= ack_d;
    end
  end

  assign dom_rst_no   = dom_q;
  assign done_o       = done_q;
  assign sw_rst_ack_o = ack_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rst_sequencer
//
// Purpose:
//   Self-checking bench for rst_sequencer (SYNC_STAGES=2, NUM_DOMAINS=3,
//   RELEASE_DELAY=4, HOLD_CYCLES=3). A timeline model tracks how many
//   edges have passed since the current release sequence started and
//   derives the released-domain count from that; a compare process checks
//   the DUT against it on every falling clock edge. Directed scenarios add
//   hand-computed literal expectations at specific edges.
// ---------------------------------------------------------------------------
module tb_rst_sequencer;

  localparam int SYNC = 2;
  localparam int NDOM = 3;
  localparam int RDLY = 4;
  localparam int HOLD = 3;

  logic            clk          = 1'b0;
  logic            async_rst_ni = 1'b1;
  logic            lock_i       = 1'b0;
  logic            sw_rst_req_i = 1'b0;
  logic [NDOM-1:0] dom_rst_no;
  logic            done_o;
  logic            sw_rst_ack_o;

  int cmp_count  = 0;
  int fail_count = 0;

  // Timeline model state
  int m_sync_cnt  = 0;
  int m_since     = 0;
  int m_hold_left = 0;
  bit m_waiting   = 1'b0;
  bit m_started   = 1'b0;
  bit m_pending   = 1'b0;
  bit m_ack       = 1'b0;
  bit model_on    = 1'b0;

  always #5 clk = ~clk;

  rst_sequencer #(
    .SYNC_STAGES  (SYNC),
    .NUM_DOMAINS  (NDOM),
    .RELEASE_DELAY(RDLY),
    .HOLD_CYCLES  (HOLD)
  ) dut (
    .clk         (clk),
    .async_rst_ni(async_rst_ni),
    .lock_i      (lock_i),
    .sw_rst_req_i(sw_rst_req_i),
    .dom_rst_no  (dom_rst_no),
    .done_o      (done_o),
    .sw_rst_ack_o(sw_rst_ack_o)
  );

  function automatic int released_count();
    int r;
    if (!m_started) return 0;
    r = 1 + m_since / RDLY;
    return (r > NDOM) ? NDOM : r;
  endfunction

  function automatic logic [NDOM-1:0] exp_dom();
    logic [NDOM-1:0] v;
    int r;
    v = '0;
    r = released_count();
    for (int i = 0; i < r; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic model_clear();
    m_sync_cnt  = 0;
    m_since     = 0;
    m_hold_left = 0;
    m_waiting   = 1'b0;
    m_started   = 1'b0;
    m_pending   = 1'b0;
    m_ack       = 1'b0;
  endtask

  task automatic note_completion();
    if (released_count() == NDOM && m_pending) begin
      m_ack     = 1'b1;
      m_pending = 1'b0;
    end
  endtask

  task automatic start_sequence();
    m_waiting   = 1'b0;
    m_hold_left = 0;
    m_started   = 1'b1;
    m_since     = 0;
    note_completion();
  endtask

  task automatic lose_lock();
    m_started   = 1'b0;
    m_hold_left = 0;
    m_waiting   = 1'b1;
    m_pending   = 1'b0;
  endtask

  always @(negedge async_rst_ni) model_clear();

  // Advance the model by one rising edge using the inputs held across it.
  always @(posedge clk) begin
    if (async_rst_ni) begin
      m_ack = 1'b0;
      if (m_sync_cnt < SYNC) begin
        m_sync_cnt++;
        if (m_sync_cnt == SYNC) m_waiting = 1'b1;
      end else if (m_waiting) begin
        if (lock_i) start_sequence();
      end else if (m_hold_left > 0) begin
        if (!lock_i) begin
          lose_lock();
        end else begin
          m_hold_left--;
          if (m_hold_left == 0) start_sequence();
        end
      end else if (m_started) begin
        if (!lock_i) begin
          lose_lock();
        end else if (sw_rst_req_i) begin
          m_started   = 1'b0;
          m_hold_left = HOLD;
          m_pending   = 1'b1;
        end else if (released_count() < NDOM) begin
          m_since++;
          note_completion();
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    cmp_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_on) begin
      checkOutput("model_dom",  32'(dom_rst_no),   32'(exp_dom()));
      checkOutput("model_done", 32'(done_o),       32'(released_count() == NDOM));
      checkOutput("model_ack",  32'(sw_rst_ack_o), 32'(m_ack));
    end
  end

  task automatic checkLiteral(input string name, input logic [NDOM-1:0] dom,
                              input logic done, input logic ack);
    checkOutput({name, "_dom"},  32'(dom_rst_no),   32'(dom));
    checkOutput({name, "_done"}, 32'(done_o),       32'(done));
    checkOutput({name, "_ack"},  32'(sw_rst_ack_o), 32'(ack));
  endtask

  task automatic applyStimulus(input logic lock, input logic sw);
    lock_i       = lock;
    sw_rst_req_i = sw;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset for three cycles, release, and follow the full power-up sequence.
  task automatic powerUp();
    async_rst_ni = 1'b0;
    applyStimulus(1'b1, 1'b0);
    repeat (3) tick();
    checkLiteral("reset_state", 3'b000, 1'b0, 1'b0);
    async_rst_ni = 1'b1;
    for (int e = 1; e <= 11; e++) begin
      tick();
      case (e)
        2:  checkLiteral("pu_edge2",  3'b000, 1'b0, 1'b0);
        3:  checkLiteral("pu_edge3",  3'b001, 1'b0, 1'b0);
        6:  checkLiteral("pu_edge6",  3'b001, 1'b0, 1'b0);
        7:  checkLiteral("pu_edge7",  3'b011, 1'b0, 1'b0);
        10: checkLiteral("pu_edge10", 3'b011, 1'b0, 1'b0);
        11: checkLiteral("pu_edge11", 3'b111, 1'b1, 1'b0);
        default: ;
      endcase
    end
  endtask

  // Software reset from RUN: hold, then re-release with an acknowledge.
  task automatic swResetTest();
    applyStimulus(1'b1, 1'b1);
    tick();
    checkLiteral("sw_edge0", 3'b000, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    for (int j = 1; j <= 12; j++) begin
      tick();
      case (j)
        2:  checkLiteral("sw_edge2",  3'b000, 1'b0, 1'b0);
        3:  checkLiteral("sw_edge3",  3'b001, 1'b0, 1'b0);
        7:  checkLiteral("sw_edge7",  3'b011, 1'b0, 1'b0);
        11: checkLiteral("sw_edge11", 3'b111, 1'b1, 1'b1);
        12: checkLiteral("sw_edge12", 3'b111, 1'b1, 1'b0);
        default: ;
      endcase
    end
  endtask

  // Lock loss while 011 during a software-initiated sequence: no ack later.
  task automatic lockLossTest();
    applyStimulus(1'b1, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0);
    repeat (8) tick();
    checkLiteral("ll_before", 3'b011, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    tick();
    checkLiteral("ll_drop", 3'b000, 1'b0, 1'b0);
    repeat (3) tick();
    checkLiteral("ll_wait", 3'b000, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    tick();
    checkLiteral("ll_first", 3'b001, 1'b0, 1'b0);
    repeat (8) tick();
    checkLiteral("ll_done", 3'b111, 1'b1, 1'b0);
    tick();
    checkLiteral("ll_after", 3'b111, 1'b1, 1'b0);
  endtask

  // Lock loss and software request on the same edge: WAIT_LOCK path wins.
  task automatic simultaneousTest();
    applyStimulus(1'b0, 1'b1);
    tick();
    checkLiteral("sim_edge0", 3'b000, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    repeat (2) tick();
    applyStimulus(1'b1, 1'b0);
    tick();
    checkLiteral("sim_first", 3'b001, 1'b0, 1'b0);
    repeat (8) tick();
    checkLiteral("sim_done", 3'b111, 1'b1, 1'b0);
  endtask

  // Lock arrives ten cycles after reset release.
  task automatic lateLockTest();
    async_rst_ni = 1'b0;
    applyStimulus(1'b0, 1'b0);
    repeat (3) tick();
    async_rst_ni = 1'b1;
    repeat (10) tick();
    checkLiteral("late_waiting", 3'b000, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    tick();
    checkLiteral("late_first", 3'b001, 1'b0, 1'b0);
    repeat (8) tick();
    checkLiteral("late_done", 3'b111, 1'b1, 1'b0);
  endtask

  // Reset asserted between clock edges while releasing.
  task automatic midCycleResetTest();
    applyStimulus(1'b1, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0);
    repeat (5) tick();
    checkLiteral("mid_release", 3'b001, 1'b0, 1'b0);
    #2;
    async_rst_ni = 1'b0;
    #1;
    checkLiteral("mid_async", 3'b000, 1'b0, 1'b0);
    powerUp();
  endtask

  task automatic randomPhase(input int cycles);
    logic l;
    logic s;
    for (int c = 0; c < cycles; c++) begin
      l = ($urandom_range(0, 29) != 0);
      s = !sw_rst_req_i && ($urandom_range(0, 14) == 0);
      applyStimulus(l, s);
      if ($urandom_range(0, 399) == 0) begin
        #2 async_rst_ni = 1'b0;
        #1 async_rst_ni = 1'b1;
      end
      tick();
    end
    applyStimulus(1'b1, 1'b0);
    repeat (30) tick();
  endtask

  initial begin
    #1;
    model_on = 1'b1;
    powerUp();
    swResetTest();
    lockLossTest();
    simultaneousTest();
    lateLockTest();
    midCycleResetTest();
    randomPhase(4000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule
